// File: rtl/column_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : column_mac_sequencer
// Purpose  : Issues `len` read strobes into a column buffer, multiplies each
//            returned word by the weight sampled at issue time and accumulates
//            the products into a partial sum. The sum is offered downstream
//            over a valid/ready handshake.
// Ports    : clk, reset (sync, active-high)
//            start, len            - job launch, honoured only when idle
//            w_data                - weight for the word issued this cycle
//            rd_req_p/rd_data_pflag- read strobe / advance flag (identical)
//            rd_data_p             - buffer data, RD_LAT cycles after flag
//            busy                  - high whenever not idle
//            psum/psum_valid/psum_ready - result handshake
// Options  : COLUMN_MAC_SAT_EN - saturating accumulation (default: wrap)
// Revision : 1.0 - initial release
// ============================================================================
module column_mac_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_WIDTH  = 24,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  rd_req_p,
  output logic                  rd_data_pflag,
  input  logic [DATA_WIDTH-1:0] rd_data_p,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  psum,
  output logic                  psum_valid,
  input  logic                  psum_ready
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t                             state_q, state_d;
  logic [CNT_W-1:0]                   len_q, len_d;
  logic [CNT_W-1:0]                   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]                   cons_cnt_q, cons_cnt_d;
  logic [ACC_WIDTH-1:0]               acc_q, acc_d;
  // Weight/valid pipe: entry 0 is written on issue, entry RD_LAT-1 lines up
  // with the buffer data returned for that issue.
  logic [RD_LAT-1:0]                  pv_q, pv_d;
  logic [RD_LAT-1:0][DATA_WIDTH-1:0]  pw_q, pw_d;

  logic                               issuing;
  logic                               consume;
  logic signed [2*DATA_WIDTH-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]        prod_ext;
  logic [ACC_WIDTH-1:0]               add_res;

  assign issuing  = (state_q == ST_ISSUE);
  assign consume  = pv_q[RD_LAT-1];
  assign prod     = $signed(rd_data_p) * $signed(pw_q[RD_LAT-1]);
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef COLUMN_MAC_SAT_EN
  // One guard bit detects signed overflow of the add; clamp to the rail
  // indicated by the true (guard) sign.
  logic [ACC_WIDTH:0] sum_wide;
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
  always_comb begin
    add_res = sum_wide[ACC_WIDTH-1:0];
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      add_res = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  assign add_res = acc_q + prod_ext;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    cons_cnt_d  = cons_cnt_q;
    acc_d       = acc_q;

    pv_d[0] = issuing;
    pw_d[0] = issuing ? w_data : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pw_d[i] = pw_q[i-1];
    end

    if (consume) begin
      acc_d      = add_res;
      cons_cnt_d = cons_cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (start && (len != '0)) begin
          len_d       = len;
          issue_cnt_d = '0;
          cons_cnt_d  = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_cnt_d = issue_cnt_q + CNT_ONE;
        if ((issue_cnt_q + CNT_ONE) == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word always lands here because RD_LAT >= 1.
        if (consume && ((cons_cnt_q + CNT_ONE) == len_q)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (psum_ready) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      cons_cnt_q  <= '0;
      acc_q       <= '0;
      pv_q        <= '0;
      pw_q        <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      cons_cnt_q  <= cons_cnt_d;
      acc_q       <= acc_d;
      pv_q        <= pv_d;
      pw_q        <= pw_d;
    end
  end

  assign rd_req_p      = issuing;
  assign rd_data_pflag = issuing;
  assign busy          = (state_q != ST_IDLE);
  assign psum_valid    = (state_q == ST_OUT);
  assign psum          = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_column_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_column_mac_sequencer
// Purpose  : Self-checking bench for column_mac_sequencer. A small column
//            buffer model returns data RD_LAT cycles after each flag; results
//            are compared to a plain-arithmetic dot-product model.
//            The DUT runs with a 16-bit accumulator so overflow is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_column_mac_sequencer;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int ACC = 16;
  localparam int RL  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   len;
  logic [DW-1:0] w_data;
  logic          rd_req_p;
  logic          rd_data_pflag;
  logic [DW-1:0] rd_data_p;
  logic          busy;
  logic [ACC-1:0] psum;
  logic          psum_valid;
  logic          psum_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  column_mac_sequencer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACC), .RD_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .w_data(w_data),
    .rd_req_p(rd_req_p), .rd_data_pflag(rd_data_pflag), .rd_data_p(rd_data_p),
    .busy(busy), .psum(psum), .psum_valid(psum_valid), .psum_ready(psum_ready)
  );

  // Column buffer and weight source. Deliberately not reset so that words
  // requested before a reset still arrive afterwards.
  int            mem_d [64];
  int            mem_w [64];
  int            rd_idx = 0;
  int            w_idx  = 0;
  logic          clr_idx = 1'b0;
  logic [DW-1:0] stage [RL];

  always @(posedge clk) begin
    if (clr_idx) begin
      rd_idx <= 0;
      w_idx  <= 0;
    end else if (rd_data_pflag) begin
      rd_idx <= rd_idx + 1;
      w_idx  <= w_idx + 1;
    end
    stage[0] <= rd_data_pflag ? DW'(mem_d[rd_idx % 64]) : '0;
    for (int i = 1; i < RL; i++) stage[i] <= stage[i-1];
  end
  assign rd_data_p = stage[RL-1];
  assign w_data    = rd_req_p ? DW'(mem_w[w_idx % 64]) : '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: dot product with per-add wrap or saturation at ACC bits.
  function automatic int model(input int n);
    longint acc = 0;
    longint lim = longint'(1) <<< (ACC - 1);
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(mem_d[i]) * longint'(mem_w[i]);
`ifdef COLUMN_MAC_SAT_EN
      if (acc > lim - 1) acc = lim - 1;
      if (acc < -lim)    acc = -lim;
`else
      acc = ((acc % (2 * lim)) + 2 * lim) % (2 * lim);
      if (acc >= lim) acc = acc - 2 * lim;
`endif
    end
    return int'(acc);
  endfunction

  // Called at a falling edge while the DUT is idle; returns at the falling
  // edge of the cycle after the handshake.
  task automatic run_job(input int n, input int exp, input int rdy);
    int t = 1, flags = 0, bad = 0, vt = -1, hold = 0, done = 0;
    clr_idx = 1'b1; start = 1'b1; len = (AW+1)'(n);
    @(posedge clk); @(negedge clk);
    clr_idx = 1'b0; start = 1'b0; len = '0;
    while (!done && t < 300) begin
      if (t == 1) check("busy_rise", int'(busy), 1);
      if (rd_req_p) begin
        flags++;
        if (t > n) bad = 1;
      end
      if (rd_req_p != rd_data_pflag) bad = 1;
      if (psum_valid) begin
        if (vt < 0) vt = t;
        check("psum", int'($signed(psum)), exp);
        if (hold >= rdy) begin
          psum_ready = 1'b1;
          done = 1;
        end else begin
          hold++;
          start = 1'b1;
          len   = (AW+1)'(3);
        end
      end
      @(posedge clk); @(negedge clk);
      start = 1'b0; len = '0; psum_ready = 1'b0;
      t++;
    end
    check("job_done", done, 1);
    check("valid_cycle", vt, n + RL + 1);
    check("flag_count", flags, n);
    check("flag_window", bad, 0);
    check("busy_fall", int'(busy), 0);
    check("valid_fall", int'(psum_valid), 0);
  endtask

  typedef struct {
    int n;
    int d[4];
    int w[4];
    int exp;
    int rdy;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{4, '{1, 2, 3, 4},         '{1, 1, 1, 1},     10,    0};
    tbl[1] = '{1, '{-128, 0, 0, 0},      '{-128, 0, 0, 0},  16384, 0};
    tbl[2] = '{2, '{5, 6, 0, 0},         '{2, 3, 0, 0},     28,    5};
    tbl[3] = '{3, '{-1, 127, -128, 0},   '{127, -1, 1, 0},  -382,  1};
    tbl[4] = '{4, '{10, -20, 30, -40},   '{-3, -3, -3, -3}, 60,    2};

    reset = 1'b1; start = 1'b0; len = '0; psum_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin mem_d[i] = 0; mem_w[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("reset_ctrl", int'({rd_req_p, rd_data_pflag, busy, psum_valid}), 0);
      check("reset_psum", int'(psum), 0);
      @(negedge clk);
    end

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        mem_d[i] = tbl[v].d[i];
        mem_w[i] = tbl[v].w[i];
      end
      run_job(tbl[v].n, tbl[v].exp, tbl[v].rdy);
    end

    // len = 0 must be ignored
    start = 1'b1; len = '0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("len0_idle", int'({busy, rd_req_p, psum_valid}), 0);
      @(negedge clk);
    end

    // Full-column job driving the accumulator past its range
    for (int i = 0; i < 64; i++) begin mem_d[i] = 127; mem_w[i] = 127; end
`ifdef COLUMN_MAC_SAT_EN
    run_job(64, 32767, 0);
`else
    run_job(64, -16320, 0);
`endif

    // Reset in cycle 2 of a len=8 job; in-flight words must be dropped
    for (int i = 0; i < 64; i++) begin mem_d[i] = 100; mem_w[i] = 3; end
    clr_idx = 1'b1; start = 1'b1; len = (AW+1)'(8);
    @(posedge clk); @(negedge clk);
    clr_idx = 1'b0; start = 1'b0; len = '0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("midjob_reset_ctrl", int'({rd_req_p, rd_data_pflag, busy, psum_valid}), 0);
    check("midjob_reset_psum", int'(psum), 0);
    mem_d[0] = 5; mem_d[1] = 6; mem_w[0] = 2; mem_w[1] = 3;
    run_job(2, 28, 0);

    // Randomized jobs against the reference model
    for (int j = 0; j < 20; j++) begin
      int n;
      n = int'($urandom_range(1, 64));
      for (int i = 0; i < n; i++) begin
        mem_d[i] = int'($urandom_range(0, 255)) - 128;
        mem_w[i] = int'($urandom_range(0, 255)) - 128;
      end
      run_job(n, model(n), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
